// File: rtl/chan_merge_pkg.sv
// chan_merge_pkg
// Shared definitions for the chan_merge block: the channel count, the
// channel index type and the arbiter state encoding.
package chan_merge_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] chan_t;

  // IDLE: output register empty. HOLD: output register holds a word.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock show-ahead FIFO. rd_data always presents the oldest entry
// while the FIFO is non-empty; rd_en pops it on the next rising edge.
// A write to a full FIFO is accepted only when a pop happens on the same
// edge, so occupancy stays unchanged. FIFO_DEPTH must be a power of two
// and at least 2.
//
// Ports:
//   clk_in    rising-edge clock
//   reset_in  asynchronous active-high reset (empties the FIFO)
//   wr_en     push wr_data this edge
//   wr_data   word to push
//   rd_en     pop the head entry this edge (caller only pops when !empty)
//   rd_data   head entry
//   full      FIFO_DEPTH entries stored
//   empty     no entries stored
module sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // One extra pointer bit distinguishes full from empty when the
  // address bits coincide.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              do_wr;
  logic              do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || rd_en);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, so resetting them discards stored words.
  always_ff @(posedge clk_in) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/chan_merge.sv
// chan_merge
// Buffers four non-stallable input streams in per-channel FIFOs and merges
// them round-robin into one valid/ready stream tagged with the source
// channel. Words arriving at a full FIFO that is not popped on the same
// edge are dropped and flagged in the sticky ovf bits.
//
// Ports:
//   clk_in                    rising-edge clock
//   reset_in                  asynchronous active-high reset
//   in_0..in_3                channel data
//   in_valid_0..in_valid_3    channel word present (no upstream ready)
//   out_data / out_chan       merged word and its source channel
//   out_valid                 output register holds a word
//   out_ready                 downstream accepts the word
//   ovf                       per-channel sticky overflow flags
module chan_merge
  import chan_merge_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic              in_valid_0,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  input  logic              in_valid_3,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        ovf
);

  logic [DATA_W-1:0] in_data [NUM_CH];
  logic [DATA_W-1:0] rd_data [NUM_CH];
  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;

  arb_state_t state;
  arb_state_t state_nxt;
  chan_t      last_grant;
  chan_t      grant;
  logic       any_ready;
  logic       load;
  logic       take;

  assign in_data[0] = in_0;
  assign in_data[1] = in_1;
  assign in_data[2] = in_2;
  assign in_data[3] = in_3;
  assign in_valid   = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
    sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .wr_en    (in_valid[i]),
      .wr_data  (in_data[i]),
      .rd_en    (pop[i]),
      .rd_data  (rd_data[i]),
      .full     (full[i]),
      .empty    (empty[i])
    );
  end

  assign any_ready = !(&empty);
  // The output register may load when empty or when its word leaves now.
  assign load      = (state == IDLE) || out_ready;
  assign take      = load && any_ready;
  assign out_valid = (state == HOLD);

  // Round-robin search starting just after the last granted channel;
  // k = 4 wraps back to last_grant itself.
  always_comb begin
    logic found;
    chan_t idx;
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    grant = last_grant;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = last_grant + chan_t'(k);
      if (!found && !empty[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (take) pop[grant] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_ready) state_nxt = HOLD;
      HOLD: if (out_ready && !any_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state      <= IDLE;
      out_data   <= '0;
      out_chan   <= '0;
      last_grant <= chan_t'(NUM_CH - 1);
      ovf        <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        out_data   <= rd_data[grant];
        out_chan   <= grant;
        last_grant <= grant;
      end
      // A write to a full FIFO survives only if that FIFO pops this edge.
      ovf <= ovf | (in_valid & full & ~pop);
    end
  end

endmodule

// File: tb/tb_chan_merge.sv
// tb_chan_merge
// Directed bench for chan_merge with DATA_W=8, FIFO_DEPTH=4. Inputs are
// driven 1 time unit after each rising edge; registered outputs are sampled
// there too. Transfers (out_valid & out_ready) are logged on the falling
// edge, just before the edge that completes them.
module tb_chan_merge;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic [7:0] in_0, in_1, in_2, in_3;
  logic       in_valid_0, in_valid_1, in_valid_2, in_valid_3;
  logic [7:0] out_data;
  logic [1:0] out_chan;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [9:0] cap_word [$];
  int         cap_cyc  [$];
  logic [9:0] exp_q    [$];

  chan_merge #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .in_0       (in_0),
    .in_1       (in_1),
    .in_2       (in_2),
    .in_3       (in_3),
    .in_valid_0 (in_valid_0),
    .in_valid_1 (in_valid_1),
    .in_valid_2 (in_valid_2),
    .in_valid_3 (in_valid_3),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf        (ovf)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    cyc++;
    if (out_valid && out_ready) begin
      cap_word.push_back({out_chan, out_data});
      cap_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic clear_cap();
    cap_word.delete();
    cap_cyc.delete();
  endtask

  // Compares the captured transfer log against exp_q, entry by entry.
  task automatic check_stream(input string tag);
    int n;
    check({tag, " count"}, cap_word.size(), exp_q.size());
    n = (cap_word.size() < exp_q.size()) ? cap_word.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, " word"}, {22'd0, cap_word[i]}, {22'd0, exp_q[i]});
  endtask

  task automatic idle_inputs();
    {in_valid_0, in_valid_1, in_valid_2, in_valid_3} = 4'b0000;
  endtask

  initial begin
    reset_in  = 1'b1;
    out_ready = 1'b1;
    in_0 = '0; in_1 = '0; in_2 = '0; in_3 = '0;
    idle_inputs();
    #12;
    reset_in = 1'b0;

    // Reset state
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_chan", out_chan, 0);
    check("rst ovf", ovf, 0);
    tick();

    // Simultaneous burst right after reset: channel 0 is served first
    clear_cap();
    in_0 = 8'd1; in_1 = 8'd2; in_2 = 8'd3; in_3 = 8'd4;
    {in_valid_0, in_valid_1, in_valid_2, in_valid_3} = 4'b1111;
    tick();
    idle_inputs();
    tick(6);
    exp_q = '{{2'd0, 8'd1}, {2'd1, 8'd2}, {2'd2, 8'd3}, {2'd3, 8'd4}};
    check_stream("burst");
    if (cap_cyc.size() == 4) check("burst back-to-back", cap_cyc[3] - cap_cyc[0], 3);
    check("burst out_valid low", out_valid, 0);

    // Single channel: word appears after the second rising edge, for one cycle
    in_2 = 8'h05; in_valid_2 = 1'b1;
    tick();
    in_valid_2 = 1'b0;
    check("single not early", out_valid, 0);
    tick();
    check("single out_valid", out_valid, 1);
    check("single out_data", out_data, 8'h05);
    check("single out_chan", out_chan, 2);
    tick();
    check("single one cycle", out_valid, 0);
    check("single ovf", ovf, 0);

    // Backpressure: last grant is 2, so channel 3 wins, then 0, then 1
    out_ready = 1'b0;
    in_0 = 8'hA0; in_1 = 8'hB1; in_3 = 8'hD3;
    {in_valid_0, in_valid_1, in_valid_3} = 3'b111;
    tick();
    idle_inputs();
    tick();
    check("bp out_valid", out_valid, 1);
    check("bp first chan", out_chan, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp held data", out_data, 8'hD3);
      check("bp held chan", out_chan, 3);
    end
    clear_cap();
    out_ready = 1'b1;
    tick(5);
    exp_q = '{{2'd3, 8'hD3}, {2'd0, 8'hA0}, {2'd1, 8'hB1}};
    check_stream("bp drain");

    // Overflow: the first word goes straight into the output register, the
    // FIFO then fills with 11..14 and 15 is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_1 = 8'(10 + i); in_valid_1 = 1'b1;
      if (i == 5) check("ovf before drop", ovf, 0);
      tick();
    end
    idle_inputs();
    check("ovf flag", ovf, 4'b0010);
    clear_cap();
    out_ready = 1'b1;
    tick(8);
    exp_q = '{{2'd1, 8'd10}, {2'd1, 8'd11}, {2'd1, 8'd12}, {2'd1, 8'd13}, {2'd1, 8'd14}};
    check_stream("ovf drain");
    check("ovf sticky", ovf, 4'b0010);

    // Reset mid-stream, between clock edges
    out_ready = 1'b0;
    in_0 = 8'h11; in_2 = 8'h22;
    {in_valid_0, in_valid_2} = 2'b11;
    tick(2);
    idle_inputs();
    #2;
    reset_in = 1'b1;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst ovf", ovf, 0);
    #2;
    reset_in = 1'b0;
    clear_cap();
    out_ready = 1'b1;
    tick(4);
    check("midrst no stale", cap_word.size(), 0);
    in_2 = 8'h77; in_valid_2 = 1'b1;
    tick();
    idle_inputs();
    tick(3);
    exp_q = '{{2'd2, 8'h77}};
    check_stream("midrst next");

    // Pointer wrap: 20 back-to-back words on channel 3
    clear_cap();
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      in_3 = 8'(8'h30 + i); in_valid_3 = 1'b1;
      exp_q.push_back({2'd3, 8'(8'h30 + i)});
      tick();
    end
    idle_inputs();
    tick(5);
    check_stream("wrap");
    check("wrap ovf", ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
